// File: rtl/dac_mcp47_multi.sv
// dac_mcp47_multi: round-robin MCP47FEBxx multi-channel DAC update engine.
// Host loads latch into per-channel shadows; each pending channel becomes one
// I2C write (addr, cmd byte, value hi, value lo, stop) on i2c_master's streams.
// Ports: clk, rst (async, active-low), ch_value/ch_load (host side),
//   busy/pending/err (status), m_cmd_* / m_data_* (to i2c_master),
//   i2c_busy/i2c_missed_ack (from i2c_master).
// Optional: define DAC_MCP47_RETRY_EN to resend failed updates (4 tries).
module dac_mcp47_multi #(
    parameter int         NUM_CH       = 2,
    parameter int         DAC_BITS     = 12,
    parameter logic [6:0] DEV_ADDR     = 7'h60,
    parameter int         WAIT_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*16-1:0]   ch_value,
    input  logic [NUM_CH-1:0]      ch_load,
    output logic                   busy,
    output logic [NUM_CH-1:0]      pending,
    output logic                   err,
    output logic [6:0]             m_cmd_address,
    output logic                   m_cmd_start,
    output logic                   m_cmd_write_multiple,
    output logic                   m_cmd_stop,
    output logic                   m_cmd_valid,
    input  logic                   m_cmd_ready,
    output logic [7:0]             m_data,
    output logic                   m_data_valid,
    input  logic                   m_data_ready,
    output logic                   m_data_last,
    input  logic                   i2c_busy,
    input  logic                   i2c_missed_ack
);

    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [15:0] VAL_MASK = 16'((32'h1 << DAC_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_D0, S_D1, S_D2, S_WAIT, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [15:0]       shadow [NUM_CH];
    logic [15:0]       tx_val;
    logic [SW-1:0]     sel, rr_ptr;
    logic [SW-1:0]     arb_sel, lo_sel, hi_sel;
    logic              arb_hit, hi_hit;
    logic              seen_busy, miss;
    logic [CW-1:0]     wait_cnt;
    logic              timeout;
    logic              resend;
    logic [NUM_CH-1:0] pending_nx;

`ifdef DAC_MCP47_RETRY_EN
    logic [2:0]        retry_cnt;
    assign resend = (retry_cnt != 3'd3);
`else
    assign resend = 1'b0;
`endif

    // Round-robin pick: lowest pending index at or above rr_ptr,
    // otherwise wrap to the lowest pending index overall.
    always_comb begin
        lo_sel = '0;
        hi_sel = '0;
        hi_hit = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (pending[j]) begin
                lo_sel = SW'(j);
                if (SW'(j) >= rr_ptr) begin
                    hi_sel = SW'(j);
                    hi_hit = 1'b1;
                end
            end
        end
        arb_hit = |pending;
        arb_sel = hi_hit ? hi_sel : lo_sel;
    end

    // A load in the same cycle as a clear or resend always leaves it pending.
    always_comb begin
        pending_nx = pending;
        if (state == S_IDLE && arb_hit)
            pending_nx[arb_sel] = 1'b0;
        if (state == S_DONE && miss && resend)
            pending_nx[sel] = 1'b1;
        pending_nx = pending_nx | ch_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        unique case (state)
            S_IDLE: if (arb_hit) state_nx = S_CMD;
            S_CMD:  if (m_cmd_ready) state_nx = S_D0;
            S_D0:   if (m_data_ready) state_nx = S_D1;
            S_D1:   if (m_data_ready) state_nx = S_D2;
            S_D2:   if (m_data_ready) state_nx = S_WAIT;
            S_WAIT: begin
                if (seen_busy && !i2c_busy) begin
                    state_nx = S_DONE;
                end else if (wait_cnt == CW'(WAIT_TIMEOUT)) begin
                    state_nx = S_DONE;
                    timeout  = 1'b1;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy                 = (state != S_IDLE);
        m_cmd_address        = '0;
        m_cmd_start          = 1'b0;
        m_cmd_write_multiple = 1'b0;
        m_cmd_stop           = 1'b0;
        m_cmd_valid          = 1'b0;
        m_data               = '0;
        m_data_valid         = 1'b0;
        m_data_last          = 1'b0;
        unique case (state)
            S_CMD: begin
                m_cmd_address        = DEV_ADDR;
                m_cmd_start          = 1'b1;
                m_cmd_write_multiple = 1'b1;
                m_cmd_stop           = 1'b1;
                m_cmd_valid          = 1'b1;
            end
            S_D0: begin
                m_data       = {5'(sel), 3'b000};
                m_data_valid = 1'b1;
            end
            S_D1: begin
                m_data       = tx_val[15:8];
                m_data_valid = 1'b1;
            end
            S_D2: begin
                m_data       = tx_val[7:0];
                m_data_valid = 1'b1;
                m_data_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++)
                shadow[i] <= '0;
            pending   <= '0;
            tx_val    <= '0;
            sel       <= '0;
            rr_ptr    <= '0;
            seen_busy <= 1'b0;
            miss      <= 1'b0;
            wait_cnt  <= '0;
            err       <= 1'b0;
`ifdef DAC_MCP47_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (ch_load[i])
                    shadow[i] <= ch_value[16*i +: 16];
            pending <= pending_nx;
            if (state == S_IDLE && arb_hit) begin
                sel    <= arb_sel;
                tx_val <= shadow[arb_sel] & VAL_MASK;
                rr_ptr <= (arb_sel == SW'(NUM_CH - 1)) ? '0 : arb_sel + 1'b1;
            end
            if (state == S_IDLE || state == S_DONE) begin
                seen_busy <= 1'b0;
                miss      <= 1'b0;
            end else begin
                if (i2c_busy)
                    seen_busy <= 1'b1;
                if (i2c_missed_ack || timeout)
                    miss <= 1'b1;
            end
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == S_DONE) begin
`ifdef DAC_MCP47_RETRY_EN
                if (!miss) begin
                    retry_cnt <= '0;
                end else if (retry_cnt == 3'd3) begin
                    err       <= 1'b1;
                    retry_cnt <= '0;
                end else begin
                    retry_cnt <= retry_cnt + 1'b1;
                end
`else
                if (miss)
                    err <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dac_mcp47_multi.sv
// tb_dac_mcp47_multi: directed table-driven bench for dac_mcp47_multi
// with a simple i2c_master stream model (ack, stall and NACK injection).
module tb_dac_mcp47_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ch_value = '0;
    logic [1:0]  ch_load = '0;
    logic        busy, err;
    logic [1:0]  pending;
    logic [6:0]  m_cmd_address;
    logic        m_cmd_start, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
    logic        m_cmd_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_data_valid, m_data_last;
    logic        m_data_ready = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        i2c_missed_ack = 1'b0;

    always #5 clk = ~clk;

    dac_mcp47_multi #(
        .NUM_CH(2), .DAC_BITS(12), .DEV_ADDR(7'h60), .WAIT_TIMEOUT(65535)
    ) dut (
        .clk(clk), .rst(rst), .ch_value(ch_value), .ch_load(ch_load),
        .busy(busy), .pending(pending), .err(err),
        .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start),
        .m_cmd_write_multiple(m_cmd_write_multiple), .m_cmd_stop(m_cmd_stop),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_data(m_data), .m_data_valid(m_data_valid),
        .m_data_ready(m_data_ready), .m_data_last(m_data_last),
        .i2c_busy(i2c_busy), .i2c_missed_ack(i2c_missed_ack)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [8:0] byte_q [$];
    logic [9:0] cmd_q [$];
    int stall_left = 0, stall_obs = 0, stall_bad = 0;
    int nack_left = 0, bidx = 0, busy_tail = 0;
    logic [7:0] stall_exp = '0;

    // i2c_master model: acks commands at once, accepts bytes (optionally
    // stalling byte 1), raises busy from command until 3 cycles after last.
    always @(negedge clk) begin
        if (!rst) begin
            m_cmd_ready = 0; m_data_ready = 0; i2c_busy = 0;
            i2c_missed_ack = 0; bidx = 0; busy_tail = 0;
        end else begin
            m_cmd_ready = 0; m_data_ready = 0; i2c_missed_ack = 0;
            if (m_cmd_valid) begin
                m_cmd_ready = 1;
                cmd_q.push_back({m_cmd_address, m_cmd_start,
                                 m_cmd_write_multiple, m_cmd_stop});
                bidx = 0; i2c_busy = 1; busy_tail = 0;
            end else if (m_data_valid) begin
                if (bidx == 1 && stall_left > 0) begin
                    stall_left--; stall_obs++;
                    if (m_data !== stall_exp) stall_bad++;
                end else begin
                    m_data_ready = 1;
                    byte_q.push_back({m_data_last, m_data});
                    if (bidx == 1 && nack_left > 0) begin
                        i2c_missed_ack = 1; nack_left--;
                    end
                    if (m_data_last) busy_tail = 3;
                    bidx++;
                end
            end else if (busy_tail > 0) begin
                busy_tail--;
                if (busy_tail == 0) i2c_busy = 0;
            end
        end
    end

    typedef struct {
        logic [1:0]      mask;
        logic [15:0]     v0, v1;
        int              nb;
        logic [5:0][8:0] exp;
    } vec_t;

    vec_t tv [5];

    function automatic vec_t mk(input logic [1:0] m, input logic [15:0] a, b,
                                input int nb, input logic [8:0] e0, e1, e2,
                                e3, e4, e5);
        vec_t r;
        r.mask = m; r.v0 = a; r.v1 = b; r.nb = nb;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2;
        r.exp[3] = e3; r.exp[4] = e4; r.exp[5] = e5;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [1:0] m, input logic [15:0] a, b);
        @(negedge clk);
        ch_value = {b, a};
        ch_load  = m;
        @(negedge clk);
        ch_load  = '0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || pending != 0) && n < 3000) begin
            @(negedge clk); n++;
        end
        chk({nm, "_timeout"}, 32'(n >= 3000), 32'd0);
    endtask

    task automatic wait_bytes(input string nm, input int cnt);
        int n = 0;
        while (byte_q.size() < cnt && n < 3000) begin
            @(negedge clk); n++;
        end
        chk({nm, "_timeout"}, 32'(n >= 3000), 32'd0);
    endtask

    task automatic chk_bytes(input string nm, input int base, input int nb,
                             input logic [5:0][8:0] exp);
        for (int k = 0; k < nb; k++)
            chk($sformatf("%s_b%0d", nm, base + k),
                (base + k < byte_q.size()) ? 32'(byte_q[base + k]) : 32'hDEAD,
                32'(exp[k]));
    endtask

    task automatic clr_q();
        byte_q.delete();
        cmd_q.delete();
    endtask

    initial begin
        tv[0] = mk(2'b10, 16'h0000, 16'hFABC, 3,
                   9'h008, 9'h00A, 9'h1BC, 9'h0, 9'h0, 9'h0);
        tv[1] = mk(2'b11, 16'h0123, 16'h0456, 6,
                   9'h000, 9'h001, 9'h123, 9'h008, 9'h004, 9'h156);
        tv[2] = mk(2'b01, 16'hFFFF, 16'h0000, 3,
                   9'h000, 9'h00F, 9'h1FF, 9'h0, 9'h0, 9'h0);
        tv[3] = mk(2'b11, 16'h0AAA, 16'h0555, 6,
                   9'h008, 9'h005, 9'h155, 9'h000, 9'h00A, 9'h1AA);
        tv[4] = mk(2'b10, 16'h0000, 16'h1234, 3,
                   9'h008, 9'h002, 9'h134, 9'h0, 9'h0, 9'h0);

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cmd", {m_cmd_address, m_cmd_start, m_cmd_write_multiple,
                        m_cmd_stop, m_cmd_valid}, 0);
        chk("rst_data", {m_data, m_data_valid, m_data_last}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            clr_q();
            load(tv[i].mask, tv[i].v0, tv[i].v1);
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_nbytes", i), 32'(byte_q.size()), 32'(tv[i].nb));
            chk_bytes($sformatf("v%0d", i), 0, tv[i].nb, tv[i].exp);
            chk($sformatf("v%0d_ncmd", i), 32'(cmd_q.size()), 32'(tv[i].nb / 3));
            for (int k = 0; k < cmd_q.size(); k++)
                chk($sformatf("v%0d_cmd%0d", i, k), 32'(cmd_q[k]), 32'h307);
            chk($sformatf("v%0d_err", i), 32'(err), 0);
        end

        // back-to-back gap: one IDLE cycle between DONE and the next CMD
        begin
            int n = 0;
            clr_q();
            load(2'b11, 16'h0123, 16'h0456);
            while (!busy && n < 100) begin @(negedge clk); n++; end
            while (busy && n < 200) begin @(negedge clk); n++; end
            chk("gap_timeout", 32'(n >= 200), 0);
            chk("gap_idle_cmd", 32'(m_cmd_valid), 0);
            chk("gap_idle_pend", 32'(pending), 32'h2);
            @(negedge clk);
            chk("gap_cmd_valid", 32'(m_cmd_valid), 1);
            wait_idle("gap");
            chk_bytes("gap", 0, 6, {9'h156, 9'h004, 9'h008,
                                    9'h123, 9'h001, 9'h000});
        end

        // stall D1 for 20 cycles
        clr_q();
        stall_exp = 8'h01; stall_left = 20; stall_obs = 0; stall_bad = 0;
        load(2'b01, 16'h0123, 16'h0000);
        wait_idle("stall");
        chk("stall_obs", 32'(stall_obs), 20);
        chk("stall_bad", 32'(stall_bad), 0);
        chk("stall_n", 32'(byte_q.size()), 3);
        chk_bytes("stall", 0, 3, {9'h0, 9'h0, 9'h0, 9'h123, 9'h001, 9'h000});

        // reload ch0 while its transfer sits in D1
        clr_q();
        stall_exp = 8'h01; stall_left = 5; stall_obs = 0; stall_bad = 0;
        load(2'b01, 16'h0111, 16'h0000);
        wait_bytes("reload", 1);
        load(2'b01, 16'h0FFF, 16'h0000);
        chk("reload_pend", 32'(pending), 1);
        chk("reload_busy", 32'(busy), 1);
        wait_idle("reload");
        chk("reload_n", 32'(byte_q.size()), 6);
        chk_bytes("reload", 0, 6, {9'h1FF, 9'h00F, 9'h000,
                                   9'h111, 9'h001, 9'h000});

        // missed ACK during D1
        clr_q();
        nack_left = 1;
        load(2'b10, 16'h0000, 16'h0222);
        wait_idle("nack1");
`ifdef DAC_MCP47_RETRY_EN
        chk("nack1_err", 32'(err), 0);
        chk("nack1_n", 32'(byte_q.size()), 6);
        chk_bytes("nack1", 0, 6, {9'h122, 9'h002, 9'h008,
                                  9'h122, 9'h002, 9'h008});
        clr_q();
        nack_left = 4;
        load(2'b10, 16'h0000, 16'h0333);
        wait_idle("nack4");
        chk("nack4_err", 32'(err), 1);
        chk("nack4_n", 32'(byte_q.size()), 12);
        chk_bytes("nack4", 9, 3, {9'h0, 9'h0, 9'h0, 9'h133, 9'h003, 9'h008});
        chk("nack4_pend", 32'(pending), 0);
`else
        chk("nack1_err", 32'(err), 1);
        chk("nack1_n", 32'(byte_q.size()), 3);
        chk_bytes("nack1", 0, 3, {9'h0, 9'h0, 9'h0, 9'h122, 9'h002, 9'h008});
        chk("nack1_pend", 32'(pending), 0);
`endif
        chk("nack_left", 32'(nack_left), 0);

        // async reset in the middle of D1
        clr_q();
        stall_exp = 8'h04; stall_left = 10;
        load(2'b01, 16'h0456, 16'h0000);
        wait_bytes("arst", 1);
        @(negedge clk);
        chk("arst_in_d1", {m_data_valid, m_data}, 32'h104);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pend", 32'(pending), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_cmd", {m_cmd_address, m_cmd_start, m_cmd_write_multiple,
                         m_cmd_stop, m_cmd_valid}, 0);
        chk("arst_data", {m_data, m_data_valid, m_data_last}, 0);
        @(negedge clk);
        rst = 1'b1;
        stall_left = 0;
        clr_q();
        repeat (6) @(negedge clk);
        chk("post_busy", 32'(busy), 0);
        chk("post_pend", 32'(pending), 0);
        chk("post_ncmd", 32'(cmd_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
